// File: rtl/bitwise_lane_checker_pkg.sv
// Shared types and golden lane function for the bitwise lane checker.
// Also used by other benches of the lane unit.
package bitwise_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    WAIT,
    CHECK,
    FIN
  } state_t;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_XOR_BITS = 4;

  // One S0 lane: XOR below the split, AND above it.
  function automatic logic lane_s0(
    input logic a,
    input logic b,
    input int   lane,
    input int   xor_bits
  );
    return (lane < xor_bits) ? (a ^ b) : (a & b);
  endfunction

endpackage

// File: rtl/bitwise_lane_checker_if.sv
// Operand/result bus between the checker and the lane unit.
// master drives operands, slave returns results.
interface bitwise_lane_checker_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] A_o;
  logic [WIDTH-1:0] B_o;
  logic [WIDTH-1:0] S0_i;
  logic [WIDTH-1:0] S1_i;

  modport master (
    output A_o,
    output B_o,
    input  S0_i,
    input  S1_i
  );

  modport slave (
    input  A_o,
    input  B_o,
    output S0_i,
    output S1_i
  );
endinterface

// File: rtl/bitwise_lane_checker_golden.sv
// Combinational reference of the 2-operand bitwise lane unit.
// S1 is OR; S0 is XOR on low lanes, AND on high lanes.
module bitwise_golden
  import bitwise_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int XOR_BITS = DEF_XOR_BITS
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s0,
  output logic [WIDTH-1:0] s1
);

  always_comb begin
    s0 = '0;
    for (int i = 0; i < WIDTH; i++) begin
      s0[i] = lane_s0(a[i], b[i], i, XOR_BITS);
    end
  end

  assign s1 = a | b;

endmodule

// File: rtl/bitwise_lane_checker.sv
// Exhaustive (A,B) sweep engine that checks a bitwise lane unit
// against the golden model, counting and capturing mismatches.
module bitwise_lane_checker
  import bitwise_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int XOR_BITS      = DEF_XOR_BITS,
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_W         = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  bitwise_lane_checker_if.master lane,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_W-1:0]      err_count,
  output logic [WIDTH-1:0]      fail_a,
  output logic [WIDTH-1:0]      fail_b
);

  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES - 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] a_q, a_n;
  logic [WIDTH-1:0] b_q, b_n;
  logic [WIDTH-1:0] fa_n, fb_n;
  logic [3:0]       cnt_q, cnt_n;
  logic [ERR_W-1:0] err_n;
  logic             pass_n;
  logic [WIDTH-1:0] g_s0, g_s1;
  logic             mismatch;

  bitwise_golden #(
    .WIDTH   (WIDTH),
    .XOR_BITS(XOR_BITS)
  ) u_golden (
    .a (a_q),
    .b (b_q),
    .s0(g_s0),
    .s1(g_s1)
  );

  assign lane.A_o = a_q;
  assign lane.B_o = b_q;
  assign mismatch = (lane.S0_i != g_s0) || (lane.S1_i != g_s1);
  assign busy     = (state != IDLE);
  assign done     = (state == FIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      err_count <= '0;
      pass      <= 1'b0;
      fail_a    <= '0;
      fail_b    <= '0;
    end else begin
      state     <= state_n;
      a_q       <= a_n;
      b_q       <= b_n;
      cnt_q     <= cnt_n;
      err_count <= err_n;
      pass      <= pass_n;
      fail_a    <= fa_n;
      fail_b    <= fb_n;
    end
  end

  always_comb begin
    state_n = state;
    a_n     = a_q;
    b_n     = b_q;
    cnt_n   = cnt_q;
    err_n   = err_count;
    pass_n  = pass;
    fa_n    = fail_a;
    fb_n    = fail_b;
    unique case (state)
      IDLE: begin
        if (start) begin
          err_n   = '0;
          pass_n  = 1'b0;
          fa_n    = '0;
          fb_n    = '0;
          a_n     = '0;
          b_n     = '0;
          state_n = DRIVE;
        end
      end
      DRIVE: begin
        cnt_n   = SETTLE_LD;
        state_n = WAIT;
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_n = CHECK;
        end else begin
          cnt_n = cnt_q - 4'd1;
        end
      end
      CHECK: begin
        if (mismatch) begin
          if (err_count != '1) begin
            err_n = err_count + ERR_W'(1);
          end
          // Only the first failing vector is kept.
          if (err_count == '0) begin
            fa_n = a_q;
            fb_n = b_q;
          end
        end
        if (a_q != ONES) begin
          a_n     = a_q + WIDTH'(1);
          state_n = DRIVE;
        end else if (b_q != ONES) begin
          a_n     = '0;
          b_n     = b_q + WIDTH'(1);
          state_n = DRIVE;
        end else begin
          state_n = FIN;
        end
      end
      FIN: begin
        pass_n  = (err_count == '0);
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bitwise_lane_checker.sv
// Bench for bitwise_lane_checker: six checker instances driving
// bench-owned lane units with injectable faults or pipeline lag.
module tb_bitwise_lane_checker;

  localparam int N = 6;

  typedef struct {
    int s1_mask;
    bit all_and;
    bit fe;
    int fa;
    int fb;
    int fm;
  } flt_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start_v [N];
  logic        busy_v  [N];
  logic        done_v  [N];
  logic        pass_v  [N];
  logic [15:0] err_v   [N];
  logic [3:0]  fa_v    [N];
  logic [3:0]  fb_v    [N];
  logic [3:0]  err3;
  logic [2:0]  fa4, fb4, fa5, fb5;

  int compared   = 0;
  int mismatched = 0;

  flt_t f0, f3, f4, f5;

  // Golden lane results from plain masked arithmetic.
  function automatic int g_s0(int w, int xb, int a, int b);
    int full = (1 << w) - 1;
    int lo   = (1 << xb) - 1;
    return (((a ^ b) & lo) | ((a & b) & ~lo)) & full;
  endfunction

  function automatic int g_s1(int w, int a, int b);
    return (a | b) & ((1 << w) - 1);
  endfunction

  function automatic int f_s0(int w, int xb, flt_t f, int a, int b);
    int r;
    r = f.all_and ? (a & b) : g_s0(w, xb, a, b);
    if (f.fe && a == f.fa && b == f.fb) r = r ^ f.fm;
    return r & ((1 << w) - 1);
  endfunction

  function automatic int f_s1(int w, flt_t f, int a, int b);
    return (a | b) & f.s1_mask & ((1 << w) - 1);
  endfunction

  function automatic flt_t clean(int w);
    flt_t f;
    f.s1_mask = (1 << w) - 1;
    f.all_and = 1'b0;
    f.fe = 1'b0;
    f.fa = 0;
    f.fb = 0;
    f.fm = 0;
    return f;
  endfunction

  bitwise_lane_checker_if #(.WIDTH(4)) if0 ();
  bitwise_lane_checker_if #(.WIDTH(4)) if1 ();
  bitwise_lane_checker_if #(.WIDTH(4)) if2 ();
  bitwise_lane_checker_if #(.WIDTH(4)) if3 ();
  bitwise_lane_checker_if #(.WIDTH(3)) if4 ();
  bitwise_lane_checker_if #(.WIDTH(3)) if5 ();

  assign if0.S0_i = 4'(f_s0(4, 2, f0, int'(if0.A_o), int'(if0.B_o)));
  assign if0.S1_i = 4'(f_s1(4, f0, int'(if0.A_o), int'(if0.B_o)));
  assign if3.S0_i = 4'(f_s0(4, 2, f3, int'(if3.A_o), int'(if3.B_o)));
  assign if3.S1_i = 4'(f_s1(4, f3, int'(if3.A_o), int'(if3.B_o)));
  assign if4.S0_i = 3'(f_s0(3, 0, f4, int'(if4.A_o), int'(if4.B_o)));
  assign if4.S1_i = 3'(f_s1(3, f4, int'(if4.A_o), int'(if4.B_o)));
  assign if5.S0_i = 3'(f_s0(3, 3, f5, int'(if5.A_o), int'(if5.B_o)));
  assign if5.S1_i = 3'(f_s1(3, f5, int'(if5.A_o), int'(if5.B_o)));

  // Lane units with three register stages between operands and results.
  logic [7:0] pa1 = 8'h0, pa2 = 8'h0, pa3 = 8'h0;
  logic [7:0] pc1 = 8'h0, pc2 = 8'h0, pc3 = 8'h0;
  always @(posedge clk) begin
    pa1 <= {if1.A_o, if1.B_o};
    pa2 <= pa1;
    pa3 <= pa2;
    pc1 <= {if2.A_o, if2.B_o};
    pc2 <= pc1;
    pc3 <= pc2;
  end
  assign if1.S0_i = 4'(g_s0(4, 2, int'(pa3[7:4]), int'(pa3[3:0])));
  assign if1.S1_i = pa3[7:4] | pa3[3:0];
  assign if2.S0_i = 4'(g_s0(4, 2, int'(pc3[7:4]), int'(pc3[3:0])));
  assign if2.S1_i = pc3[7:4] | pc3[3:0];

  bitwise_lane_checker #(
    .WIDTH(4), .XOR_BITS(2), .SETTLE_CYCLES(1), .ERR_W(16)
  ) u0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .lane(if0),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
    .err_count(err_v[0]), .fail_a(fa_v[0]), .fail_b(fb_v[0])
  );

  bitwise_lane_checker #(
    .WIDTH(4), .XOR_BITS(2), .SETTLE_CYCLES(3), .ERR_W(16)
  ) u1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .lane(if1),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
    .err_count(err_v[1]), .fail_a(fa_v[1]), .fail_b(fb_v[1])
  );

  bitwise_lane_checker #(
    .WIDTH(4), .XOR_BITS(2), .SETTLE_CYCLES(1), .ERR_W(16)
  ) u2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .lane(if2),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
    .err_count(err_v[2]), .fail_a(fa_v[2]), .fail_b(fb_v[2])
  );

  bitwise_lane_checker #(
    .WIDTH(4), .XOR_BITS(2), .SETTLE_CYCLES(1), .ERR_W(4)
  ) u3 (
    .clk(clk), .rst(rst), .start(start_v[3]), .lane(if3),
    .busy(busy_v[3]), .done(done_v[3]), .pass(pass_v[3]),
    .err_count(err3), .fail_a(fa_v[3]), .fail_b(fb_v[3])
  );

  bitwise_lane_checker #(
    .WIDTH(3), .XOR_BITS(0), .SETTLE_CYCLES(2), .ERR_W(16)
  ) u4 (
    .clk(clk), .rst(rst), .start(start_v[4]), .lane(if4),
    .busy(busy_v[4]), .done(done_v[4]), .pass(pass_v[4]),
    .err_count(err_v[4]), .fail_a(fa4), .fail_b(fb4)
  );

  bitwise_lane_checker #(
    .WIDTH(3), .XOR_BITS(3), .SETTLE_CYCLES(1), .ERR_W(16)
  ) u5 (
    .clk(clk), .rst(rst), .start(start_v[5]), .lane(if5),
    .busy(busy_v[5]), .done(done_v[5]), .pass(pass_v[5]),
    .err_count(err_v[5]), .fail_a(fa5), .fail_b(fb5)
  );

  assign err_v[3] = {12'h000, err3};
  assign fa_v[4]  = {1'b0, fa4};
  assign fb_v[4]  = {1'b0, fb4};
  assign fa_v[5]  = {1'b0, fa5};
  assign fb_v[5]  = {1'b0, fb5};

  // Walk every (A,B), B outer, against the faulted unit.
  task automatic model_fault(input int w, input int xb, input flt_t f,
                             input int ew, output int errs,
                             output int fa, output int fb);
    int full = (1 << w) - 1;
    int n = 0;
    fa = 0;
    fb = 0;
    for (int b = 0; b <= full; b++) begin
      for (int a = 0; a <= full; a++) begin
        if (f_s0(w, xb, f, a, b) != g_s0(w, xb, a, b) ||
            f_s1(w, f, a, b) != g_s1(w, a, b)) begin
          if (n == 0) begin
            fa = a;
            fb = b;
          end
          n++;
        end
      end
    end
    errs = (n > (1 << ew) - 1) ? (1 << ew) - 1 : n;
  endtask

  // Unit whose results show the previous vector at check time.
  task automatic model_lag(input int w, input int xb, output int errs,
                           output int fa, output int fb);
    int full = (1 << w) - 1;
    int pa = 0, pb = 0;
    errs = 0;
    fa = 0;
    fb = 0;
    for (int b = 0; b <= full; b++) begin
      for (int a = 0; a <= full; a++) begin
        if (g_s0(w, xb, pa, pb) != g_s0(w, xb, a, b) ||
            g_s1(w, pa, pb) != g_s1(w, a, b)) begin
          if (errs == 0) begin
            fa = a;
            fb = b;
          end
          errs++;
        end
        pa = a;
        pb = b;
      end
    end
  endtask

  task automatic run_sweep(input int k, input int budget, input int repulse,
                           output int n_done, output logic busy1,
                           output logic pass1, output logic done_after);
    int n;
    @(negedge clk);
    start_v[k] = 1'b1;
    @(negedge clk);
    start_v[k] = 1'b0;
    n = 1;
    busy1 = busy_v[k];
    pass1 = pass_v[k];
    n_done = 0;
    while (n < budget && n_done == 0) begin
      start_v[k] = (n == repulse);
      @(negedge clk);
      n++;
      if (done_v[k]) n_done = n;
    end
    start_v[k] = 1'b0;
    @(negedge clk);
    done_after = done_v[k];
  endtask

  task automatic test_reset();
    compared++;
    if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || pass_v[0] !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_flags: busy=%b done=%b pass=%b want 000",
               busy_v[0], done_v[0], pass_v[0]);
    end
    compared++;
    if (err_v[0] !== 16'h0 || fa_v[0] !== 4'h0 || fb_v[0] !== 4'h0) begin
      mismatched++;
      $display("FAIL reset_err: err=%0d fa=%h fb=%h want 0", err_v[0],
               fa_v[0], fb_v[0]);
    end
    compared++;
    if (if0.A_o !== 4'h0 || if0.B_o !== 4'h0) begin
      mismatched++;
      $display("FAIL reset_ops: A=%h B=%h want 0 0", if0.A_o, if0.B_o);
    end
  endtask

  task automatic check_sweep(input string nm, input int k, input int n_done,
                             input int exp_n, input int errs, input int fa,
                             input int fb);
    compared++;
    if (n_done !== exp_n) begin
      mismatched++;
      $display("FAIL %s_latency: done at %0d want %0d", nm, n_done, exp_n);
    end
    compared++;
    if (int'(err_v[k]) !== errs) begin
      mismatched++;
      $display("FAIL %s_err: got %0d want %0d", nm, err_v[k], errs);
    end
    compared++;
    if (pass_v[k] !== (errs == 0)) begin
      mismatched++;
      $display("FAIL %s_pass: got %b want %b", nm, pass_v[k], errs == 0);
    end
    if (errs != 0) begin
      compared++;
      if (int'(fa_v[k]) !== fa || int'(fb_v[k]) !== fb) begin
        mismatched++;
        $display("FAIL %s_first: got %h/%h want %h/%h", nm, fa_v[k],
                 fb_v[k], fa, fb);
      end
    end
  endtask

  task automatic test_clean();
    int nd, e, fa, fb;
    logic b1, p1, da;
    f0 = clean(4);
    model_fault(4, 2, f0, 16, e, fa, fb);
    run_sweep(0, 2000, 0, nd, b1, p1, da);
    check_sweep("clean", 0, nd, 769, e, fa, fb);
    compared++;
    if (b1 !== 1'b1 || da !== 1'b0) begin
      mismatched++;
      $display("FAIL clean_busy_pulse: busy1=%b done_after=%b want 1 0",
               b1, da);
    end
    compared++;
    if (if0.A_o !== 4'hf || if0.B_o !== 4'hf || fa_v[0] !== 4'h0) begin
      mismatched++;
      $display("FAIL clean_hold: A=%h B=%h fa=%h want f f 0", if0.A_o,
               if0.B_o, fa_v[0]);
    end
  endtask

  task automatic test_s1_stuck();
    int nd, e, fa, fb;
    logic b1, p1, da;
    f0 = clean(4);
    f0.s1_mask = 7;
    model_fault(4, 2, f0, 16, e, fa, fb);
    run_sweep(0, 2000, 0, nd, b1, p1, da);
    compared++;
    if (p1 !== 1'b0) begin
      mismatched++;
      $display("FAIL stuck_pass_clear: got %b want 0", p1);
    end
    check_sweep("stuck", 0, nd, 769, e, fa, fb);
    compared++;
    if (fa_v[0] !== 4'h8 || fb_v[0] !== 4'h0) begin
      mismatched++;
      $display("FAIL stuck_first_const: got %h/%h want 8/0", fa_v[0],
               fb_v[0]);
    end
  endtask

  task automatic test_all_and();
    int nd, e, fa, fb;
    logic b1, p1, da;
    f0 = clean(4);
    f0.all_and = 1'b1;
    model_fault(4, 2, f0, 16, e, fa, fb);
    run_sweep(0, 2000, 0, nd, b1, p1, da);
    check_sweep("all_and", 0, nd, 769, e, fa, fb);
    compared++;
    if (fa_v[0] !== 4'h1 || fb_v[0] !== 4'h0) begin
      mismatched++;
      $display("FAIL all_and_first_const: got %h/%h want 1/0", fa_v[0],
               fb_v[0]);
    end
  endtask

  task automatic test_random_faults();
    int nd, e, fa, fb;
    logic b1, p1, da;
    for (int it = 0; it < 3; it++) begin
      f0 = clean(4);
      if ($urandom_range(0, 1) == 1) f0.s1_mask = $urandom_range(0, 15);
      f0.fe = ($urandom_range(0, 3) != 0);
      f0.fa = $urandom_range(0, 15);
      f0.fb = $urandom_range(0, 15);
      f0.fm = $urandom_range(1, 15);
      model_fault(4, 2, f0, 16, e, fa, fb);
      run_sweep(0, 2000, 0, nd, b1, p1, da);
      check_sweep("random", 0, nd, 769, e, fa, fb);
    end
  endtask

  task automatic test_pipeline();
    int nd, e, fa, fb;
    logic b1, p1, da;
    run_sweep(1, 3000, 0, nd, b1, p1, da);
    check_sweep("pipe_settle3", 1, nd, 1281, 0, 0, 0);
    model_lag(4, 2, e, fa, fb);
    run_sweep(2, 2000, 0, nd, b1, p1, da);
    check_sweep("pipe_settle1", 2, nd, 769, e, fa, fb);
    compared++;
    if (err_v[2] === 16'h0 || fa_v[2] !== 4'h1 || fb_v[2] !== 4'h0) begin
      mismatched++;
      $display("FAIL pipe_first_const: err=%0d fa=%h fb=%h want >0 1 0",
               err_v[2], fa_v[2], fb_v[2]);
    end
  endtask

  task automatic test_saturate();
    int nd, e, fa, fb;
    logic b1, p1, da;
    f3 = clean(4);
    f3.s1_mask = 7;
    model_fault(4, 2, f3, 4, e, fa, fb);
    run_sweep(3, 2000, 0, nd, b1, p1, da);
    check_sweep("saturate", 3, nd, 769, e, fa, fb);
    compared++;
    if (err3 !== 4'hf) begin
      mismatched++;
      $display("FAIL saturate_const: got %0d want 15", err3);
    end
  endtask

  task automatic test_lane_extremes();
    int nd, e, fa, fb;
    logic b1, p1, da;
    for (int it = 0; it < 2; it++) begin
      f4 = clean(3);
      f5 = clean(3);
      f4.fe = (it == 1);
      f5.fe = (it == 1);
      f4.fa = $urandom_range(0, 7);
      f4.fb = $urandom_range(0, 7);
      f4.fm = $urandom_range(1, 7);
      f5.fa = $urandom_range(0, 7);
      f5.fb = $urandom_range(0, 7);
      f5.fm = $urandom_range(1, 7);
      model_fault(3, 0, f4, 16, e, fa, fb);
      run_sweep(4, 1000, 0, nd, b1, p1, da);
      check_sweep("all_and_lanes", 4, nd, 257, e, fa, fb);
      model_fault(3, 3, f5, 16, e, fa, fb);
      run_sweep(5, 1000, 0, nd, b1, p1, da);
      check_sweep("all_xor_lanes", 5, nd, 193, e, fa, fb);
    end
  endtask

  task automatic test_reset_mid();
    int nd, seen;
    logic b1, p1, da;
    f0 = clean(4);
    f0.s1_mask = 7;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (99) @(negedge clk);
    compared++;
    if (busy_v[0] !== 1'b1 || err_v[0] === 16'h0) begin
      mismatched++;
      $display("FAIL mid_progress: busy=%b err=%0d want 1 >0", busy_v[0],
               err_v[0]);
    end
    rst = 1'b1;
    @(negedge clk);
    compared++;
    if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || err_v[0] !== 16'h0 ||
        fa_v[0] !== 4'h0 || if0.A_o !== 4'h0 || if0.B_o !== 4'h0) begin
      mismatched++;
      $display("FAIL mid_reset: busy=%b done=%b err=%0d fa=%h A=%h B=%h",
               busy_v[0], done_v[0], err_v[0], fa_v[0], if0.A_o, if0.B_o);
    end
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (done_v[0] || busy_v[0]) seen++;
    end
    compared++;
    if (seen !== 0) begin
      mismatched++;
      $display("FAIL rst_wins_no_done: %0d active cycles want 0", seen);
    end
    f0 = clean(4);
    run_sweep(0, 2000, 0, nd, b1, p1, da);
    check_sweep("after_reset", 0, nd, 769, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    int nd, e, fa, fb;
    logic b1, p1, da;
    f0 = clean(4);
    run_sweep(0, 2000, 50, nd, b1, p1, da);
    check_sweep("start_busy", 0, nd, 769, 0, 0, 0);
    f0.fe = 1'b1;
    f0.fa = $urandom_range(0, 15);
    f0.fb = $urandom_range(0, 15);
    f0.fm = $urandom_range(1, 15);
    model_fault(4, 2, f0, 16, e, fa, fb);
    run_sweep(0, 2000, 0, nd, b1, p1, da);
    check_sweep("back_to_back", 0, nd, 769, e, fa, fb);
  endtask

  initial begin
    for (int k = 0; k < N; k++) start_v[k] = 1'b0;
    f0 = clean(4);
    f3 = clean(4);
    f4 = clean(3);
    f5 = clean(3);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_clean();
    test_s1_stuck();
    test_all_and();
    test_random_faults();
    test_pipeline();
    test_saturate();
    test_lane_extremes();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared,
             mismatched);
    $finish;
  end

endmodule
